// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the pipeline stage registers
package pipe_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    localparam int FD_W = 96;
    localparam int DE_W = 160;
    localparam int EM_W = 128;

    // pc field sits in the top word so it comes out of reset at the boot address
    localparam logic [FD_W-1:0] RST_DATA_FD = {RESET_PC, 64'h0};

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_wrap_ctr.sv
// rtl/pipe_wrap_ctr.sv - modulo counter 0..MAX with clear, used for buffer pointers
module pipe_wrap_ctr #(
    parameter int MAX = 1,
    parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] val
);

    localparam logic [W-1:0] LAST = W'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            val <= '0;
        end else if (inc) begin
            val <= (val == LAST) ? '0 : val + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready stage register with flush
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = FD_W,
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] RST_DATA = DATA_W'(RST_DATA_FD),
    parameter bit                BYPASS   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    generate
        if (BYPASS) begin : g_bypass
            assign s_ready = m_ready;
            assign m_valid = s_valid;
            assign m_data  = s_data;
            assign count   = '0;
        end else begin : g_buf
            localparam int PW = ptr_w(DEPTH);
            localparam int CW = $clog2(DEPTH + 1);
            localparam logic [CW-1:0] FULL = CW'(DEPTH);

            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] last;
            logic [PW-1:0]     rptr;
            logic [PW-1:0]     wptr;
            logic [CW-1:0]     cnt;
            logic              push;
            logic              pop;

            // handshake flags come from cnt only, so m_ready never reaches s_ready
            assign s_ready = (cnt < FULL);
            assign m_valid = (cnt != '0);
            assign push    = s_valid && s_ready && !flush;
            assign pop     = m_valid && m_ready && !flush;

            pipe_wrap_ctr #(.MAX(DEPTH - 1), .W(PW)) u_wptr (
                .clk (clk),
                .rst (rst),
                .clr (flush),
                .inc (push),
                .val (wptr)
            );

            pipe_wrap_ctr #(.MAX(DEPTH - 1), .W(PW)) u_rptr (
                .clk (clk),
                .rst (rst),
                .clr (flush),
                .inc (pop),
                .val (rptr)
            );

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wptr] <= s_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    cnt <= '0;
                end else if (push && !pop) begin
                    cnt <= cnt + CW'(1);
                end else if (pop && !push) begin
                    cnt <= cnt - CW'(1);
                end
            end

            // an empty stage keeps showing the last payload it handed on
            always_ff @(posedge clk) begin
                if (rst) begin
                    last <= RST_DATA;
                end else if (pop) begin
                    last <= mem[rptr];
                end
            end

            assign m_data = m_valid ? mem[rptr] : last;
            assign count  = cnt;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

    localparam logic [95:0] RST_EXP = {32'h8000_0000, 64'h0};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sv, mr, fl, sr, mv;
    logic [95:0] sd [3];
    logic [95:0] md [3];
    logic [1:0]  c2, c3;
    logic [0:0]  c1;
    logic        bsv, bmr, bfl, bsr, bmv;
    logic [95:0] bsd, bmd;
    logic [1:0]  bc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(fl[0]), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
        .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .count(c2));
    pipe_stage_elastic #(.DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(fl[1]), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
        .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .count(c3));
    pipe_stage_elastic #(.DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(fl[2]), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
        .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]), .count(c1));
    pipe_stage_elastic #(.BYPASS(1'b1)) dutb (
        .clk(clk), .rst(rst), .flush(bfl), .s_valid(bsv), .s_ready(bsr), .s_data(bsd),
        .m_valid(bmv), .m_ready(bmr), .m_data(bmd), .count(bc));

    // behavioural model: an ordered list per instance plus the last value handed out
    int          dep [3] = '{2, 3, 1};
    logic [95:0] mq [3][8];
    int          msz [3];
    logic [95:0] mlast [3];

    typedef struct {
        logic        v, r, f;
        logic [95:0] d;
        logic        emv, esr;
        int          ecnt;
        logic [95:0] emd;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] cnt_of(input int i);
        case (i)
            0:       return 96'(c2);
            1:       return 96'(c3);
            default: return 96'(c1);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            msz[i]   = 0;
            mlast[i] = RST_EXP;
        end
    endtask

    task automatic model_check(input int i, input string tag);
        chk($sformatf("%s_m_valid_%0d", tag, i), 96'(mv[i]), 96'(msz[i] != 0));
        chk($sformatf("%s_s_ready_%0d", tag, i), 96'(sr[i]), 96'(msz[i] < dep[i]));
        chk($sformatf("%s_count_%0d", tag, i), cnt_of(i), 96'(msz[i]));
        chk($sformatf("%s_m_data_%0d", tag, i), md[i], (msz[i] > 0) ? mq[i][0] : mlast[i]);
    endtask

    task automatic model_step(input int i);
        logic push, pop;
        push = sv[i] && (msz[i] < dep[i]) && !fl[i];
        pop  = (msz[i] != 0) && mr[i] && !fl[i];
        if (fl[i]) begin
            msz[i] = 0;
        end else begin
            if (pop) begin
                mlast[i] = mq[i][0];
                for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                msz[i]--;
            end
            if (push) begin
                mq[i][msz[i]] = sd[i];
                msz[i]++;
            end
        end
    endtask

    task automatic row(input int n, input logic v, input logic r, input logic f, input logic [95:0] d,
                       input logic emv, input logic esr, input int ecnt, input logic [95:0] emd);
        tbl[n] = '{v, r, f, d, emv, esr, ecnt, emd};
    endtask

    task automatic do_reset();
        sv  = '0; mr = '0; fl = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int x1, x2;
        for (int i = 0; i < 3; i++) sd[i] = '0;
        bsv = 1'b0; bmr = 1'b0; bfl = 1'b0; bsd = '0;

        //      n   v     r     f     data         mv    sr    cnt  m_data
        row(0,  1'b1, 1'b1, 1'b0, 96'h11, 1'b0, 1'b1, 0, RST_EXP);
        row(1,  1'b1, 1'b1, 1'b0, 96'h22, 1'b1, 1'b1, 1, 96'h11);
        row(2,  1'b1, 1'b1, 1'b0, 96'h33, 1'b1, 1'b1, 1, 96'h22);
        row(3,  1'b0, 1'b1, 1'b0, 96'h0,  1'b1, 1'b1, 1, 96'h33);
        row(4,  1'b0, 1'b0, 1'b0, 96'h0,  1'b0, 1'b1, 0, 96'h33);
        row(5,  1'b1, 1'b0, 1'b0, 96'h44, 1'b0, 1'b1, 0, 96'h33);
        row(6,  1'b1, 1'b0, 1'b0, 96'h55, 1'b1, 1'b1, 1, 96'h44);
        row(7,  1'b1, 1'b0, 1'b0, 96'h66, 1'b1, 1'b0, 2, 96'h44);
        row(8,  1'b1, 1'b1, 1'b0, 96'h66, 1'b1, 1'b0, 2, 96'h44);
        row(9,  1'b1, 1'b0, 1'b0, 96'h66, 1'b1, 1'b1, 1, 96'h55);
        row(10, 1'b0, 1'b0, 1'b0, 96'h0,  1'b1, 1'b0, 2, 96'h55);
        row(11, 1'b1, 1'b1, 1'b1, 96'h77, 1'b1, 1'b0, 2, 96'h55);
        row(12, 1'b1, 1'b0, 1'b1, 96'h88, 1'b0, 1'b1, 0, 96'h44);
        row(13, 1'b0, 1'b0, 1'b0, 96'h0,  1'b0, 1'b1, 0, 96'h44);

        do_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            model_check(i, "reset");
            chk($sformatf("reset_pc_%0d", i), 96'(md[i][95:64]), 96'h8000_0000);
        end

        for (int n = 0; n < 14; n++) begin
            sv[0] = tbl[n].v; mr[0] = tbl[n].r; fl[0] = tbl[n].f; sd[0] = tbl[n].d;
            #1;
            chk($sformatf("tbl%0d_m_valid", n), 96'(mv[0]), 96'(tbl[n].emv));
            chk($sformatf("tbl%0d_s_ready", n), 96'(sr[0]), 96'(tbl[n].esr));
            chk($sformatf("tbl%0d_count", n), 96'(c2), 96'(tbl[n].ecnt));
            chk($sformatf("tbl%0d_m_data", n), md[0], tbl[n].emd);
            @(posedge clk);
            #1;
        end

        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                sv[i] = ($urandom_range(0, 3) != 0);
                mr[i] = $urandom_range(0, 1) == 1;
                fl[i] = ($urandom_range(0, 15) == 0);
                sd[i] = {$urandom, $urandom, $urandom};
            end
            #1;
            for (int i = 0; i < 3; i++) model_check(i, "rand");
            for (int i = 0; i < 3; i++) model_step(i);
            @(posedge clk);
            #1;
        end

        // sustained throughput with both sides always willing
        do_reset();
        x1 = 0; x2 = 0;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 3; i++) begin
                sv[i] = 1'b1; mr[i] = 1'b1; fl[i] = 1'b0;
                sd[i] = 96'(c + 1);
            end
            #1;
            if (mv[0] && mr[0]) x2++;
            if (mv[2] && mr[2]) x1++;
            for (int i = 0; i < 3; i++) model_check(i, "thru");
            for (int i = 0; i < 3; i++) model_step(i);
            @(posedge clk);
            #1;
        end
        chk("depth1_transfers", 96'(x1), 96'd5);
        chk("depth2_transfers", 96'(x2), 96'd9);

        for (int c = 0; c < 8; c++) begin
            bsv = $urandom_range(0, 1) == 1;
            bmr = $urandom_range(0, 1) == 1;
            bfl = (c % 3) == 0;
            bsd = {$urandom, $urandom, $urandom};
            #1;
            chk("bypass_m_data", bmd, bsd);
            chk("bypass_m_valid", 96'(bmv), 96'(bsv));
            chk("bypass_s_ready", 96'(bsr), 96'(bmr));
            chk("bypass_count", 96'(bc), 96'd0);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
